gun_crosshair: RTL and testbench
================================

Name: gun_crosshair

Overview:
- Light-gun front end for the shooter game.
- Converts a binned mouse position into screen coordinates and draws a crosshair sprite in the VGA pixel stream.
- Issues single-cycle shot strobes on left-button press, then locks out further shots for a fixed cooldown.
- Sits between the mouse binning logic and the hit-test / frame compositor.

Parameters:
- BIN_W, 6, width of the bin_x/bin_y mouse bin indices.
- BIN_SIZE, 10, pixels per bin.
- CD_TICKS, 19_999_999, cooldown terminal count (0.4 s at 50 MHz). The counter width is ceil(log2(CD_TICKS)).
- RADIUS, 32, crosshair half-size. The sprite box is 2*RADIUS square.
- MAX_H, 480, screen height used for Y inversion.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  reserved; ignored.
- x  in  10  current VGA pixel column.
- y  in  9  current VGA pixel row.
- bin_x  in  BIN_W  mouse X bin.
- bin_y  in  BIN_W  mouse Y bin; mouse Y increases upward.
- button_left  in  1  left mouse button level.
- shoot_x  out  10  crosshair centre X.
- shoot_y  out  9  crosshair centre Y.
- shot  out  1  shot strobe.
- render  out  1  crosshair pixel at (x,y), registered.

Behaviour:
- Coordinate conversion (combinational):
  - shoot_x = (bin_x*BIN_SIZE) truncated to 10 bits.
  - shoot_y = (MAX_H − (bin_y*BIN_SIZE truncated to 9 bits)) mod 512.
  - Both outputs are independent of clk and reset.
- Crosshair box top-left corner is (shoot_x − RADIUS, shoot_y − RADIUS).
- Renderer:
  - dx = x − left and dy = y − top, computed signed with at least 11 bits. A crosshair near the left or top edge is clipped, never wrapped.
  - Pixel is "in box" when 0 ≤ dx < 2R and 0 ≤ dy < 2R.
  - Pattern within the box, where R = RADIUS:
    - vertical bar: dx ∈ {R−1, R};
    - horizontal bar: dy ∈ {R−1, R};
    - 2-pixel square outline: dx ∈ {0, 1, 2R−2, 2R−1} or dy ∈ {0, 1, 2R−2, 2R−1}.
  - render is the registered pattern result: 1 cycle latency after (x,y). It resets to 0.
- State machine, states IDLE and CD:
  - Reset state is IDLE.
  - shot = (state==IDLE) & button_left. It is combinational, so it is visible in the same cycle the button is seen.
  - IDLE → CD when shot=1.
  - CD → IDLE when the cooldown count equals CD_TICKS.
- Cooldown counter:
  - Synchronous clear to 0 on any cycle with shot=1.
  - Otherwise increments by 1 per cycle while in CD.
  - Saturates at CD_TICKS; it never wraps.
  - Async reset sets it to 0.
- Cooldown timing:
  - After the shot cycle, state is CD with count 0.
  - The count reaches CD_TICKS after CD_TICKS cycles in CD, and the FSM returns to IDLE on the following edge.
- Button handling:
  - A held button_left fires again on the first IDLE cycle after cooldown. No edge detection is required.
  - button_left in CD has no effect, and shot stays 0.
- Reset asserted mid-cooldown: immediately go to IDLE, clear the counter, set render=0. shot may then assert as soon as reset_n is high and button_left=1.
- Reset values:
  - shot: 0 while the button is low.
  - render: 0.
  - shoot_x, shoot_y: combinational from the bin inputs.

Test Plan:
- bin_x=6, bin_y=9 → shoot_x=60, shoot_y=390. bin_x=0, bin_y=0 → shoot_x=0, shoot_y=480.
- Reset released, button_left=1 → shot=1 in the same cycle. The next cycle shot=0 with the button still held. With CD_TICKS=5, shot re-asserts exactly CD_TICKS+2 cycles after the first strobe.
- During cooldown, toggle button_left → shot stays 0. Assert reset_n=0 mid-cooldown with the button held → shot=1 right after release.
- Centre (60,390), RADIUS=32: (x,y)=(60,390) → render=1 one cycle later. (45,375) → 0. (28,358) → 1 (corner). (92,390) → 0 (outside box).
- bin_x=1 (centre x=10): x=0, y=centre → render=1 (horizontal bar clipped at left). x=1018 → render=0 (no wraparound).
- Saturation: with CD_TICKS=3, hold in CD → counter never exceeds 3 and the FSM returns to IDLE.

Source files
------------

// File: rtl/gun_crosshair.sv
// gun_crosshair: light-gun front end.
// Turns a binned mouse position into screen coordinates. Draws a crosshair
// sprite into the VGA pixel stream with one cycle of latency. Issues a
// single-cycle shot strobe and then locks out further shots for a cooldown.
//
// Handshake note: there is no valid/ready pair on this block.
//   - shot is a pure strobe. It is high for exactly the cycles in which the
//     FSM is IDLE and button_left is high.
//   - The downstream hit-test must sample shoot_x/shoot_y in that same cycle.
module gun_crosshair #(
    parameter int BIN_W    = 6,
    parameter int BIN_SIZE = 10,
    parameter int CD_TICKS = 19_999_999,
    parameter int RADIUS   = 32,
    parameter int MAX_H    = 480
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic [BIN_W-1:0] bin_x,
    input  logic [BIN_W-1:0] bin_y,
    input  logic             button_left,
    output logic [9:0]       shoot_x,
    output logic [8:0]       shoot_y,
    output logic             shot,
    output logic             render
);

    // The counter must be able to hold CD_TICKS itself. The +1 keeps that
    // true when CD_TICKS is an exact power of two.
    localparam int CNT_W = (CD_TICKS < 2) ? 1 : $clog2(CD_TICKS + 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(CD_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Sprite geometry constants in the signed 12-bit offset domain.
    localparam logic signed [11:0] R_S      = 12'(RADIUS);
    localparam logic signed [11:0] R_M1     = 12'(RADIUS - 1);
    localparam logic signed [11:0] TWO_R    = 12'(2 * RADIUS);
    localparam logic signed [11:0] TWO_R_M1 = 12'(2 * RADIUS - 1);
    localparam logic signed [11:0] TWO_R_M2 = 12'(2 * RADIUS - 2);
    localparam logic signed [11:0] ZERO_S   = 12'sd0;
    localparam logic signed [11:0] ONE_S    = 12'sd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CD   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
    logic             render_q, render_d;

    // ------------------------------------------------------------------
    // Coordinate conversion. Purely combinational; mouse Y grows upward,
    // so it is flipped against the screen height.
    // ------------------------------------------------------------------
    logic [31:0] prod_x;
    logic [31:0] prod_y;
    logic [31:0] inv_y;

    assign prod_x  = 32'(bin_x) * 32'(BIN_SIZE);
    assign prod_y  = 32'(bin_y) * 32'(BIN_SIZE);
    assign inv_y   = 32'(MAX_H) - 32'(prod_y[8:0]);
    assign shoot_x = prod_x[9:0];
    assign shoot_y = inv_y[8:0];

    // start is reserved. The high product bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = &{1'b0, start, prod_x[31:10], prod_y[31:9], inv_y[31:9]};

    // ------------------------------------------------------------------
    // Renderer. The offsets are signed, so a crosshair hanging off the left
    // or top edge produces a negative corner. That corner clips instead of
    // wrapping to the far side of the screen.
    // ------------------------------------------------------------------
    logic signed [11:0] left_s;
    logic signed [11:0] top_s;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic               in_box;
    logic               vbar;
    logic               hbar;
    logic               outline_x;
    logic               outline_y;

    // Box-relative pixel offsets and the pattern decode.
    always_comb begin
        left_s    = $signed({2'b00, shoot_x}) - R_S;
        top_s     = $signed({3'b000, shoot_y}) - R_S;
        dx        = $signed({2'b00, x}) - left_s;
        dy        = $signed({3'b000, y}) - top_s;
        in_box    = (dx >= ZERO_S) && (dx < TWO_R) &&
                    (dy >= ZERO_S) && (dy < TWO_R);
        vbar      = (dx == R_M1) || (dx == R_S);
        hbar      = (dy == R_M1) || (dy == R_S);
        outline_x = (dx == ZERO_S) || (dx == ONE_S) ||
                    (dx == TWO_R_M2) || (dx == TWO_R_M1);
        outline_y = (dy == ZERO_S) || (dy == ONE_S) ||
                    (dy == TWO_R_M2) || (dy == TWO_R_M1);
        render_d  = in_box && (vbar || hbar || outline_x || outline_y);
    end

    // Pixel pipeline register: render lags (x,y) by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            render_q <= 1'b0;
        end else begin
            render_q <= render_d;
        end
    end

    assign render = render_q;

    // ------------------------------------------------------------------
    // Shot / cooldown FSM
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Leaving CD waits for the counter to sit at its
    // terminal value, which adds one cycle beyond CD_TICKS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (shot)                  state_d = CD;
            CD:   if (cd_cnt_q == CD_LAST)   state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // FSM outputs. A held button fires again on the first IDLE cycle.
    always_comb begin
        shot = 1'b0;
        if (state_q == IDLE) begin
            shot = button_left;
        end
    end

    // Cooldown counter next value. It clears on a shot, counts while in CD,
    // and saturates at CD_LAST.
    always_comb begin
        cd_cnt_d = cd_cnt_q;
        if (shot) begin
            cd_cnt_d = '0;
        end else if ((state_q == CD) && (cd_cnt_q != CD_LAST)) begin
            cd_cnt_d = cd_cnt_q + CNT_ONE;
        end
    end

    // Cooldown counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cd_cnt_q <= '0;
        end else begin
            cd_cnt_q <= cd_cnt_d;
        end
    end

endmodule

// File: tb/tb_gun_crosshair.sv
// Directed testbench for gun_crosshair.
// Two instances share all inputs: one with a cooldown of 5, one with 3.
module tb_gun_crosshair;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [9:0] x;
  logic [8:0] y;
  logic [5:0] bin_x;
  logic [5:0] bin_y;
  logic       button_left;

  logic [9:0] shoot_x, shoot_x_s;
  logic [8:0] shoot_y, shoot_y_s;
  logic       shot, shot_s;
  logic       render, render_s;

  int n_checks;
  int n_fail;

  gun_crosshair #(
    .BIN_W(6), .BIN_SIZE(10), .CD_TICKS(5), .RADIUS(32), .MAX_H(480)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y),
    .bin_x(bin_x), .bin_y(bin_y), .button_left(button_left),
    .shoot_x(shoot_x), .shoot_y(shoot_y), .shot(shot), .render(render)
  );

  gun_crosshair #(
    .BIN_W(6), .BIN_SIZE(10), .CD_TICKS(3), .RADIUS(32), .MAX_H(480)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y),
    .bin_x(bin_x), .bin_y(bin_y), .button_left(button_left),
    .shoot_x(shoot_x_s), .shoot_y(shoot_y_s), .shot(shot_s), .render(render_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    button_left = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    button_left = 1'b0;
    @(negedge clk);
    n_checks++;
    if (shot !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_shot: got %b expected 0", shot);
    end
    n_checks++;
    if (render !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_render: got %b expected 0", render);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_coords();
    logic [5:0] bx [4] = '{6'd6, 6'd0, 6'd63, 6'd63};
    logic [5:0] by [4] = '{6'd9, 6'd0, 6'd63, 6'd50};
    logic [9:0] ex [4] = '{10'd60, 10'd0, 10'd630, 10'd630};
    logic [8:0] ey [4] = '{9'd390, 9'd480, 9'd362, 9'd492};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bin_x = bx[i];
      bin_y = by[i];
      #1;
      n_checks++;
      if (shoot_x !== ex[i]) begin
        n_fail++;
        $display("FAIL coord_x[%0d]: got %0d expected %0d", i, shoot_x, ex[i]);
      end
      n_checks++;
      if (shoot_y !== ey[i]) begin
        n_fail++;
        $display("FAIL coord_y[%0d]: got %0d expected %0d", i, shoot_y, ey[i]);
      end
    end
  endtask

  // The button is held throughout. The first strobe is in cycle 0, the
  // re-strobe is in cycle CD_TICKS+2 = 7, and cycles 1..6 must stay quiet.
  task automatic test_shot_cooldown();
    logic exp;
    apply_reset();
    button_left = 1'b1;
    #1;
    n_checks++;
    if (shot !== 1'b1) begin
      n_fail++;
      $display("FAIL shot_first: got %b expected 1", shot);
    end
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      exp = (n == 7);
      n_checks++;
      if (shot !== exp) begin
        n_fail++;
        $display("FAIL shot_cycle[%0d]: got %b expected %b", n, shot, exp);
      end
    end
    @(negedge clk);
    button_left = 1'b0;
  endtask

  task automatic test_cd_button();
    apply_reset();
    button_left = 1'b1;
    @(negedge clk);
    // The FSM is in CD for cycles 1..6. Toggling the button must not fire.
    for (int n = 1; n <= 4; n++) begin
      button_left = n[0];
      #1;
      n_checks++;
      if (shot !== 1'b0) begin
        n_fail++;
        $display("FAIL cd_toggle[%0d]: got %b expected 0", n, shot);
      end
      @(negedge clk);
    end
    // Reset mid-cooldown with the button held.
    button_left = 1'b1;
    reset_n     = 1'b0;
    #1;
    n_checks++;
    if (render !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_reset_render: got %b expected 0", render);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (shot !== 1'b1) begin
      n_fail++;
      $display("FAIL cd_reset_release: got %b expected 1", shot);
    end
    @(negedge clk);
    n_checks++;
    if (shot !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_reset_next: got %b expected 0", shot);
    end
    button_left = 1'b0;
  endtask

  // Back-to-back pixels. Each negedge checks the vector applied one cycle
  // earlier, then drives the next vector.
  task automatic test_render();
    // Centre (60,390): left=28, top=358, R=32
    logic [9:0] vx [8] = '{10'd60, 10'd45, 10'd28, 10'd92, 10'd91, 10'd60, 10'd29, 10'd30};
    logic [8:0] vy [8] = '{9'd390, 9'd375, 9'd358, 9'd390, 9'd390, 9'd357, 9'd380, 9'd380};
    logic       ev [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    bin_x = 6'd6;
    bin_y = 6'd9;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (render !== ev[i-1]) begin
          n_fail++;
          $display("FAIL render[%0d] (%0d,%0d): got %b expected %b",
                   i - 1, vx[i-1], vy[i-1], render, ev[i-1]);
        end
      end
      if (i < 8) begin
        x = vx[i];
        y = vy[i];
      end
    end
  endtask

  task automatic test_clip();
    // Cases 0-1: centre (10,390), left=-22. Cases 2-3: centre (10,30), top=-2.
    logic [5:0] by [4] = '{6'd9, 6'd9, 6'd45, 6'd45};
    logic [9:0] vx [4] = '{10'd0, 10'd1018, 10'd10, 10'd10};
    logic [8:0] vy [4] = '{9'd390, 9'd390, 9'd0, 9'd510};
    logic       ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bin_x = 6'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bin_y = by[i];
      x     = vx[i];
      y     = vy[i];
      @(negedge clk);
      n_checks++;
      if (render !== ev[i]) begin
        n_fail++;
        $display("FAIL clip[%0d] (%0d,%0d): got %b expected %b",
                 i, vx[i], vy[i], render, ev[i]);
      end
    end
  endtask

  // CD_TICKS=3 instance: the count runs 0,1,2,3 over cycles 1..4 and
  // never goes past 3. The FSM is IDLE again in cycle 5.
  task automatic test_saturation();
    int cnt;
    apply_reset();
    button_left = 1'b1;
    @(negedge clk);
    button_left = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      cnt = int'(dut_sat.cd_cnt_q);
      n_checks++;
      if (cnt !== n - 1) begin
        n_fail++;
        $display("FAIL sat_count[%0d]: got %0d expected %0d", n, cnt, n - 1);
      end
      if (n == 4) begin
        button_left = 1'b1;
        #1;
        n_checks++;
        if (shot_s !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_cd_last: got %b expected 0", shot_s);
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (shot_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_idle_again: got %b expected 1", shot_s);
    end
    button_left = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    x           = '0;
    y           = '0;
    bin_x       = '0;
    bin_y       = '0;
    button_left = 1'b0;
    test_reset();
    test_coords();
    test_shot_cooldown();
    test_cd_button();
    test_render();
    test_clip();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
